// File: rtl/uart_btn_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_btn_cmd_arbiter_if
// Groups the command-source inputs (buttons, uart_rx) and the issued control
// pulses / echo outputs of uart_btn_cmd_arbiter into one bundle.
//   slave  : arbiter side (consumes i_*, drives o_*)
//   master : source/sink side (drives i_*, observes o_*)
// Signals:
//   i_rx_data[7:0], i_rx_done           : UART receive byte + strobe
//   i_btn_run/clear/mode/up/down        : debounced one-cycle button pulses
//   i_tx_busy                           : uart_tx busy (echo build only)
//   o_run_stop/o_clear/o_mode/o_up/o_down : issued one-cycle command pulses
//   o_err, o_overrun                    : bad byte / dropped byte pulses
//   o_tx_start, o_tx_data[7:0]          : echo strobe and byte
// ---------------------------------------------------------------------------
interface uart_btn_cmd_arbiter_if;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_btn_run;
    logic       i_btn_clear;
    logic       i_btn_mode;
    logic       i_btn_up;
    logic       i_btn_down;
    logic       i_tx_busy;
    logic       o_run_stop;
    logic       o_clear;
    logic       o_mode;
    logic       o_up;
    logic       o_down;
    logic       o_err;
    logic       o_overrun;
    logic       o_tx_start;
    logic [7:0] o_tx_data;

    modport slave (
        input  i_rx_data, i_rx_done, i_btn_run, i_btn_clear, i_btn_mode,
               i_btn_up, i_btn_down, i_tx_busy,
        output o_run_stop, o_clear, o_mode, o_up, o_down, o_err, o_overrun,
               o_tx_start, o_tx_data
    );

    modport master (
        output i_rx_data, i_rx_done, i_btn_run, i_btn_clear, i_btn_mode,
               i_btn_up, i_btn_down, i_tx_busy,
        input  o_run_stop, o_clear, o_mode, o_up, o_down, o_err, o_overrun,
               o_tx_start, o_tx_data
    );
endinterface

// File: rtl/uart_btn_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// uart_btn_cmd_arbiter
// Merges debounced button pulses and ASCII UART command bytes into a single
// stream of one-cycle control pulses, with LOCKOUT_CYCLES idle cycles forced
// after every issued pulse. Buttons always win over UART.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : uart_btn_cmd_arbiter_if.slave (sources in, command pulses out)
// Parameters:
//   LOCKOUT_CYCLES : idle cycles after each issued pulse (>= 1)
// Build option:
//   ECHO_ACK_EN : when defined, every UART-sourced command is echoed once on
//                 o_tx_start/o_tx_data after its lockout (waits out i_tx_busy).
//                 When undefined, o_tx_start/o_tx_data are 0, i_tx_busy ignored.
// Command one-hot bit order everywhere: {DOWN, UP, MODE, CLR, RUN}.
// ---------------------------------------------------------------------------
module uart_btn_cmd_arbiter #(
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_btn_cmd_arbiter_if.slave  bus
);

    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
`ifdef ECHO_ACK_EN
        , ACK
`endif
    } state_t;

    // Case-insensitive decode: OR-ing 0x20 folds each upper-case command
    // letter onto its lower-case code and maps no other byte onto one.
    function automatic logic [4:0] decode(input logic [7:0] b);
        logic [7:0] lc;
        lc = b | 8'h20;
        case (lc)
            8'h72:   decode = 5'b00001;
            8'h63:   decode = 5'b00010;
            8'h6d:   decode = 5'b00100;
            8'h75:   decode = 5'b01000;
            8'h64:   decode = 5'b10000;
            default: decode = 5'b00000;
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [4:0]       btn_in, btn_pend, pick_btn, rx_cmd;
    logic             any_btn, take, take_uart, rx_valid, slot_free;
    logic             slot_vld;
    logic [4:0]       slot_cmd;
    logic [7:0]       slot_byte;
    logic [4:0]       cur_cmd;
    logic             cur_uart;
    logic [7:0]       cur_byte;
    logic [CNT_W-1:0] cnt;
    logic             err, overrun, issue;

    assign btn_in    = {bus.i_btn_down, bus.i_btn_up, bus.i_btn_mode,
                        bus.i_btn_clear, bus.i_btn_run};
    assign any_btn   = |btn_pend;
    // Isolate the lowest set bit: RUN sits at bit 0, so it has top priority.
    assign pick_btn  = btn_pend & (~btn_pend + 5'd1);
    assign take_uart = take & ~any_btn;
    assign rx_cmd    = decode(bus.i_rx_data);
    assign rx_valid  = |rx_cmd;
    // The slot can accept a byte on the same edge that empties it.
    assign slot_free = ~slot_vld | take_uart;

`ifdef ECHO_ACK_EN
    logic       echo_fire;
    logic       tx_start;
    logic [7:0] tx_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
`ifdef ECHO_ACK_EN
        echo_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_btn || slot_vld) begin
                    take      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = HOLD;
            HOLD: begin
                if (cnt == CNT_LAST) begin
`ifdef ECHO_ACK_EN
                    state_nxt = cur_uart ? ACK : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef ECHO_ACK_EN
            ACK: begin
                if (!bus.i_tx_busy) begin
                    echo_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_pend  <= '0;
            slot_vld  <= 1'b0;
            slot_cmd  <= '0;
            slot_byte <= '0;
            cur_cmd   <= '0;
            cur_uart  <= 1'b0;
            cur_byte  <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A new pulse on the consuming edge survives as a fresh request.
            btn_pend <= (btn_pend & ~(take ? pick_btn : 5'd0)) | btn_in;
            err      <= bus.i_rx_done & ~rx_valid;
            overrun  <= bus.i_rx_done & rx_valid & ~slot_free;
            if (bus.i_rx_done && rx_valid && slot_free) begin
                slot_vld  <= 1'b1;
                slot_cmd  <= rx_cmd;
                slot_byte <= bus.i_rx_data;
            end else if (take_uart) begin
                slot_vld  <= 1'b0;
            end
            if (take) begin
                cur_cmd  <= any_btn ? pick_btn : slot_cmd;
                cur_uart <= ~any_btn;
                cur_byte <= slot_byte;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == HOLD) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign issue          = (state == ISSUE);
    assign bus.o_run_stop = issue & cur_cmd[0];
    assign bus.o_clear    = issue & cur_cmd[1];
    assign bus.o_mode     = issue & cur_cmd[2];
    assign bus.o_up       = issue & cur_cmd[3];
    assign bus.o_down     = issue & cur_cmd[4];
    assign bus.o_err      = err;
    assign bus.o_overrun  = overrun;

`ifdef ECHO_ACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= echo_fire;
            tx_data  <= echo_fire ? cur_byte : 8'h00;
        end
    end

    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_data;
`else
    // Source tag, raw byte and tx busy only matter to the echo path.
    logic unused_echo;
    assign unused_echo    = ^{cur_uart, cur_byte, bus.i_tx_busy};
    assign bus.o_tx_start = 1'b0;
    assign bus.o_tx_data  = 8'h00;
`endif

endmodule
